// File: rtl/s13207_mon_pkg.sv
// Shared types and helpers for the s13207 g9280 observation monitor.
// Holds the FSM state enum, the default MISR taps and a saturating increment.

package s13207_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } mon_state_e;

   // Default MISR feedback taps (bit i set = tap i).
   localparam logic [15:0] MISR_POLY_DEF = 16'hB400;

   // Widest counter sat_inc can handle.
   localparam int unsigned SAT_MAX_W = 32;

   // Increment v, holding at 2^w-1 instead of wrapping.
   // The counter is zero-extended into 32 bits by the caller.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input int unsigned w
   );
      logic [31:0] lim;
      if (w >= SAT_MAX_W) begin
         lim = 32'hFFFF_FFFF;
      end else begin
         lim = (32'd1 << w) - 32'd1;
      end
      if (v >= lim) begin
         return lim;
      end
      return v + 32'd1;
   endfunction

endpackage

// File: rtl/s13207_g9280_obs_monitor_misr.sv
// obs_misr: serial-input MISR compacting the faulty-copy g9280 stream.
// Ports: clk, rst (sync, active high), clr (zero the signature),
//        en (shift in din this cycle), din (serial bit), sig (signature).

module obs_misr
   import s13207_mon_pkg::*;
#(
   parameter int unsigned           MISR_W    = 16,
   parameter logic [MISR_W-1:0]     MISR_POLY = MISR_W'(MISR_POLY_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              din,
   output logic [MISR_W-1:0] sig
);

   logic [MISR_W-1:0] sig_q;
   logic [MISR_W-1:0] sig_d;
   logic [MISR_W-1:0] shifted;

   always_comb begin
      shifted = {sig_q[MISR_W-2:0], 1'b0};
      if (sig_q[MISR_W-1]) begin
         shifted = shifted ^ MISR_POLY;
      end
      sig_d = sig_q;
      // A clear and a shift never coincide in the top, but clear wins.
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = {shifted[MISR_W-1:1], shifted[0] ^ din};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/s13207_g9280_obs_monitor.sv
// Observer for the g9280 cone: compares golden vs faulty copies per vector,
// counts mismatches (saturating), captures the first failing vector index
// and compacts the faulty stream into a MISR signature.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, num_vec            campaign start pulse and vector count
//   obs_valid, obs_ready      sample handshake (ready only in RUN)
//   golden_g9280/faulty_g9280 the two cone outputs for this vector
//   busy, done                campaign status (RUN/DRAIN vs DONE)
//   err_count                 saturating mismatch count
//   first_err_vld/_idx        first mismatching vector index
//   signature                 MISR of the faulty stream

module s13207_g9280_obs_monitor
   import s13207_mon_pkg::*;
#(
   parameter int unsigned        IDX_W     = 16,
   parameter int unsigned        CNT_W     = 16,
   parameter int unsigned        MISR_W    = 16,
   parameter logic [MISR_W-1:0]  MISR_POLY = MISR_W'(MISR_POLY_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IDX_W-1:0]  num_vec,
   input  logic              obs_valid,
   output logic              obs_ready,
   input  logic              golden_g9280,
   input  logic              faulty_g9280,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  err_count,
   output logic              first_err_vld,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic [MISR_W-1:0] signature
);

   // FSM and campaign bookkeeping
   mon_state_e       state_q;
   mon_state_e       state_d;
   logic [IDX_W-1:0] cnt_q;
   logic [IDX_W-1:0] cnt_d;
   logic [IDX_W-1:0] nvec_q;
   logic [IDX_W-1:0] nvec_d;

   // Stage 1: registered transfer
   logic             s1_vld_q;
   logic             s1_vld_d;
   logic             s1_gold_q;
   logic             s1_gold_d;
   logic             s1_flt_q;
   logic             s1_flt_d;
   logic [IDX_W-1:0] s1_idx_q;
   logic [IDX_W-1:0] s1_idx_d;

   // Stage 2: result registers
   logic [CNT_W-1:0] err_q;
   logic [CNT_W-1:0] err_d;
   logic             fvld_q;
   logic             fvld_d;
   logic [IDX_W-1:0] fidx_q;
   logic [IDX_W-1:0] fidx_d;

   // Decoded events
   logic             start_ok;
   logic             xfer;
   logic             last_xfer;
   logic             mism;

   always_comb begin
      start_ok  = start &&
                  ((state_q == ST_IDLE) ||
                   (state_q == ST_DONE));
      xfer      = obs_valid && (state_q == ST_RUN);
      last_xfer = xfer &&
                  (cnt_q == nvec_q - IDX_W'(1));
      mism      = s1_vld_q &&
                  (s1_gold_q ^ s1_flt_q);
   end

   // Next state. DRAIN gives the last stage-1
   // entry one cycle to retire before done.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      nvec_d  = nvec_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               nvec_d = num_vec;
               cnt_d  = '0;
               if (num_vec == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (xfer) begin
               cnt_d = cnt_q + IDX_W'(1);
               if (last_xfer) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Stage 1 capture and stage 2 update.
   always_comb begin
      s1_vld_d  = xfer;
      s1_gold_d = s1_gold_q;
      s1_flt_d  = s1_flt_q;
      s1_idx_d  = s1_idx_q;
      if (xfer) begin
         s1_gold_d = golden_g9280;
         s1_flt_d  = faulty_g9280;
         s1_idx_d  = cnt_q;
      end

      err_d  = err_q;
      fvld_d = fvld_q;
      fidx_d = fidx_q;
      if (mism) begin
         err_d = CNT_W'(sat_inc(32'(err_q), CNT_W));
         if (!fvld_q) begin
            fvld_d = 1'b1;
            fidx_d = s1_idx_q;
         end
      end

      // Stage 1 is always empty in IDLE/DONE,
      // so a clear never drops a live sample.
      if (start_ok) begin
         err_d    = '0;
         fvld_d   = 1'b0;
         fidx_d   = '0;
         s1_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         nvec_q    <= '0;
         s1_vld_q  <= 1'b0;
         s1_gold_q <= 1'b0;
         s1_flt_q  <= 1'b0;
         s1_idx_q  <= '0;
         err_q     <= '0;
         fvld_q    <= 1'b0;
         fidx_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         nvec_q    <= nvec_d;
         s1_vld_q  <= s1_vld_d;
         s1_gold_q <= s1_gold_d;
         s1_flt_q  <= s1_flt_d;
         s1_idx_q  <= s1_idx_d;
         err_q     <= err_d;
         fvld_q    <= fvld_d;
         fidx_q    <= fidx_d;
      end
   end

   obs_misr #(
      .MISR_W    (MISR_W),
      .MISR_POLY (MISR_POLY)
   ) u_misr (
      .clk (clk),
      .rst (rst),
      .clr (start_ok),
      .en  (s1_vld_q),
      .din (s1_flt_q),
      .sig (signature)
   );

   assign obs_ready     = (state_q == ST_RUN);
   assign busy          = (state_q == ST_RUN) ||
                          (state_q == ST_DRAIN);
   assign done          = (state_q == ST_DONE);
   assign err_count     = err_q;
   assign first_err_vld = fvld_q;
   assign first_err_idx = fidx_q;

endmodule

// File: tb/tb_s13207_g9280_obs_monitor.sv
// Bench for s13207_g9280_obs_monitor: table campaigns, reset corners and
// random campaigns against a queue-based model; a CNT_W=4 copy checks saturation.

module tb_s13207_g9280_obs_monitor;

   localparam logic [15:0] POLY = 16'hB400;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] num_vec = '0;
   logic        obs_valid = 1'b0;
   logic        golden = 1'b0;
   logic        faulty = 1'b0;

   logic        obs_ready, busy, done, fvld;
   logic [15:0] err_count, fidx, sig;
   logic        obs_ready4, busy4, done4, fvld4;
   logic [3:0]  err4;
   logic [15:0] fidx4, sig4;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: one entry per transfer (edge number, mismatch, faulty bit)
   int xp[$];
   bit xm[$];
   bit xf[$];

   typedef struct {
      int          nv;
      logic [63:0] g;
      logic [63:0] f;
      logic [63:0] gp;
      bit          poke;
      int          exp_err;
      int          exp_err4;
      int          exp_fvld;
      int          exp_fidx;
      logic [15:0] exp_sig;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   s13207_g9280_obs_monitor dut (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
      .obs_valid(obs_valid), .obs_ready(obs_ready),
      .golden_g9280(golden), .faulty_g9280(faulty),
      .busy(busy), .done(done), .err_count(err_count),
      .first_err_vld(fvld), .first_err_idx(fidx),
      .signature(sig)
   );

   s13207_g9280_obs_monitor #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
      .obs_valid(obs_valid), .obs_ready(obs_ready4),
      .golden_g9280(golden), .faulty_g9280(faulty),
      .busy(busy4), .done(done4), .err_count(err4),
      .first_err_vld(fvld4), .first_err_idx(fidx4),
      .signature(sig4)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      n_chk++;
      if ((busy && done) || (busy4 && done4)) begin
         n_err++;
         $display("FAIL busy_done_excl: got busy=%0b done=%0b expected not both",
                  busy, done);
      end
   endtask

   // A transfer at edge p is visible in the outputs from edge p+1 on.
   function automatic bool_ret(input int i);
      return (xp[i] <= cyc - 1);
   endfunction

   function automatic int m_err();
      int n = 0;
      for (int i = 0; i < xp.size(); i++)
         if (bool_ret(i) && xm[i]) n++;
      return n;
   endfunction

   function automatic int m_fidx();
      for (int i = 0; i < xp.size(); i++)
         if (bool_ret(i) && xm[i]) return i;
      return -1;
   endfunction

   function automatic int m_sig();
      int s = 0;
      int old;
      for (int i = 0; i < xp.size(); i++) begin
         if (bool_ret(i)) begin
            old = s;
            s = (s * 2) % 65536;
            if (old >= 32768) s = s ^ int'(POLY);
            s = s ^ int'(xf[i]);
         end
      end
      return s;
   endfunction

   task automatic check_state(input string tag);
      int e, fi;
      e  = m_err();
      fi = m_fidx();
      chk({tag, "_err"}, 32'(err_count), 32'(e));
      chk({tag, "_err4"}, 32'(err4), 32'((e > 15) ? 15 : e));
      chk({tag, "_fvld"}, 32'(fvld), 32'(fi >= 0));
      chk({tag, "_fidx"}, 32'(fidx), 32'((fi >= 0) ? fi : 0));
      chk({tag, "_sig"}, 32'(sig), 32'(m_sig()));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, 32'(obs_ready), 32'(0));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_done"}, 32'(done), 32'(0));
      chk({tag, "_err"}, 32'(err_count), 32'(0));
      chk({tag, "_fvld"}, 32'(fvld), 32'(0));
      chk({tag, "_fidx"}, 32'(fidx), 32'(0));
      chk({tag, "_sig"}, 32'(sig), 32'(0));
      chk({tag, "_err4"}, 32'(err4), 32'(0));
      chk({tag, "_done4"}, 32'(done4), 32'(0));
   endtask

   task automatic run(input int nv, input logic [63:0] g,
                      input logic [63:0] f, input logic [63:0] gp,
                      input bit poke);
      xp.delete();
      xm.delete();
      xf.delete();
      // start and obs_valid together: start wins, no transfer
      start     = 1'b1;
      num_vec   = 16'(nv);
      obs_valid = 1'b1;
      golden    = 1'b0;
      faulty    = 1'b1;
      tick();
      start     = 1'b0;
      obs_valid = 1'b0;
      chk("clr_err", 32'(err_count), 32'(0));
      chk("clr_sig", 32'(sig), 32'(0));
      chk("clr_fvld", 32'(fvld), 32'(0));
      chk("start_done", 32'(done), 32'(nv == 0));
      chk("start_busy", 32'(busy), 32'(nv != 0));
      for (int i = 0; i < nv; i++) begin
         if (gp[i]) begin
            obs_valid = 1'b0;
            tick();
            check_state("gap");
         end
         obs_valid = 1'b1;
         golden    = g[i];
         faulty    = f[i];
         if (poke && i == nv / 2) begin
            start   = 1'b1;
            num_vec = 16'd3;
         end
         chk("ready", 32'(obs_ready), 32'(1));
         tick();
         start = 1'b0;
         xp.push_back(cyc);
         xm.push_back(g[i] ^ f[i]);
         xf.push_back(f[i]);
         check_state("run");
         chk("run_done", 32'(done), 32'(0));
      end
      obs_valid = 1'b0;
      if (nv != 0) begin
         chk("drain_busy", 32'(busy), 32'(1));
         tick();
         check_state("fin");
         chk("done_lat", 32'(done), 32'(1));
         chk("done_busy", 32'(busy), 32'(0));
      end
      // samples offered in DONE are ignored
      obs_valid = 1'b1;
      golden    = 1'b0;
      faulty    = 1'b1;
      chk("done_ready", 32'(obs_ready), 32'(0));
      tick();
      tick();
      obs_valid = 1'b0;
      check_state("post");
      chk("post_done", 32'(done), 32'(1));
   endtask

   initial begin
      tbl[0] = '{8, 64'hFF, 64'hFF, 64'h0, 1'b0,
                 0, 0, 0, 0, 16'h00FF};
      tbl[1] = '{10, 64'h0, 64'h218, 64'h0A5, 1'b1,
                 3, 3, 1, 3, 16'h0061};
      tbl[2] = '{5, 64'h1F, 64'h0, 64'h0, 1'b0,
                 5, 5, 1, 0, 16'h0000};
      tbl[3] = '{1, 64'h0, 64'h1, 64'h1, 1'b0,
                 1, 1, 1, 0, 16'h0001};
      tbl[4] = '{16, 64'hAAAA, 64'h2AAA, 64'h0, 1'b1,
                 1, 1, 1, 15, 16'h5554};
      tbl[5] = '{20, 64'h0, 64'hFFFFF, 64'h0, 1'b0,
                 20, 15, 1, 0, 16'h83FF};

      // Reset held 3 cycles
      rst = 1'b1;
      repeat (3) tick();
      check_zero("rst");
      rst = 1'b0;

      // num_vec = 0 goes straight to DONE
      run(0, 64'h0, 64'h0, 64'h0, 1'b0);

      // Table campaigns, each restarted from DONE
      for (int t = 0; t < 6; t++) begin
         run(tbl[t].nv, tbl[t].g, tbl[t].f, tbl[t].gp, tbl[t].poke);
         chk("tbl_err", 32'(err_count), 32'(tbl[t].exp_err));
         chk("tbl_err4", 32'(err4), 32'(tbl[t].exp_err4));
         chk("tbl_fvld", 32'(fvld), 32'(tbl[t].exp_fvld));
         chk("tbl_fidx", 32'(fidx), 32'(tbl[t].exp_fidx));
         chk("tbl_sig", 32'(sig), 32'(tbl[t].exp_sig));
      end

      // Reset one cycle after the 5th of 8 transfers
      xp.delete();
      xm.delete();
      xf.delete();
      start   = 1'b1;
      num_vec = 16'd8;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         obs_valid = 1'b1;
         golden    = 1'b0;
         faulty    = (i == 2 || i == 4);
         tick();
         xp.push_back(cyc);
         xm.push_back(faulty);
         xf.push_back(faulty);
         check_state("pre_rst");
      end
      obs_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      xp.delete();
      xm.delete();
      xf.delete();
      check_zero("mid_rst");
      repeat (3) tick();
      check_zero("after_rst");

      // Random campaigns
      for (int r = 0; r < 12; r++) begin
         int nv;
         logic [63:0] g, f, gp;
         nv = int'($urandom_range(0, 40));
         g  = {$urandom, $urandom};
         f  = {$urandom, $urandom};
         gp = {$urandom, $urandom} & {$urandom, $urandom};
         run(nv, g, f, gp, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
